// File: rtl/aurora_lane_striper.sv
// Multi-lane transmit striper: packs consecutive user words of a frame round-robin
// across the enabled lanes and presents each completed row to all lanes for one cycle.
module aurora_lane_striper #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    link_ready,
  input  logic [LANES-1:0]        lane_mask,
  input  logic                    s_axi_valid,
  output logic                    s_axi_ready,
  input  logic                    s_axi_last,
  input  logic [DATA_W-1:0]       s_axi_data,
  output logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES*2-1:0]      lane_kind,
  output logic [CNT_W-1:0]        frame_count
);

  localparam int unsigned SLOT_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] KIND_IDLE  = 2'b00;
  localparam logic [1:0] KIND_DATA  = 2'b01;
  localparam logic [1:0] KIND_LAST  = 2'b10;
  localparam logic [1:0] KIND_ABORT = 2'b11;

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  state_t                         state_q, state_d;
  logic [LANES-1:0]               mask_q, mask_d;
  logic [SLOT_W-1:0]              slot_q, slot_d;
  logic [LANES-1:0][DATA_W-1:0]   rowbuf_data_q, rowbuf_data_d;
  logic [LANES-1:0][1:0]          rowbuf_kind_q, rowbuf_kind_d;
  logic [LANES-1:0][DATA_W-1:0]   out_data_q, out_data_d;
  logic [LANES-1:0][1:0]          out_kind_q, out_kind_d;
  logic [CNT_W-1:0]               count_q, count_d;

  logic [LANES-1:0]               m_eff, m_cur;
  logic [SLOT_W-1:0]              s_cur, nxt_slot;
  logic                           has_nxt, abort_hit, accept;
  logic [LANES-1:0][DATA_W-1:0]   row_data;
  logic [LANES-1:0][1:0]          row_kind;

  function automatic logic [SLOT_W-1:0] low_bit(input logic [LANES-1:0] m);
    logic found;
    found   = 1'b0;
    low_bit = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!found && m[i]) begin
        low_bit = SLOT_W'(i);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [SLOT_W-1:0] high_bit(input logic [LANES-1:0] m);
    high_bit = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (m[i]) high_bit = SLOT_W'(i);
    end
  endfunction

  assign s_axi_ready = link_ready && !rst;
  assign accept      = s_axi_valid && s_axi_ready;
  assign m_eff       = (lane_mask == '0) ? LANES'(1) : lane_mask;
  assign lane_data   = out_data_q;
  assign lane_kind   = out_kind_q;
  assign frame_count = count_q;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    slot_d        = slot_q;
    rowbuf_data_d = rowbuf_data_q;
    rowbuf_kind_d = rowbuf_kind_q;
    out_data_d    = '0;
    out_kind_d    = '0;
    count_d       = count_q;

    // Frame start takes the live mask; mid-frame the latched one governs.
    m_cur = (state_q == S_FRAME) ? mask_q : m_eff;
    s_cur = (state_q == S_FRAME) ? slot_q : low_bit(m_eff);

    row_data        = rowbuf_data_q;
    row_kind        = rowbuf_kind_q;
    row_data[s_cur] = s_axi_data;
    row_kind[s_cur] = s_axi_last ? KIND_LAST : KIND_DATA;

    has_nxt  = 1'b0;
    nxt_slot = s_cur;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!has_nxt && m_cur[i] && (SLOT_W'(i) > s_cur)) begin
        has_nxt  = 1'b1;
        nxt_slot = SLOT_W'(i);
      end
    end

    abort_hit = 1'b0;
    if (state_q == S_FRAME && !link_ready) begin
      out_data_d = rowbuf_data_q;
      out_kind_d = rowbuf_kind_q;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!abort_hit && mask_q[i] && rowbuf_kind_q[i] == KIND_IDLE) begin
          out_kind_d[i] = KIND_ABORT;
          abort_hit     = 1'b1;
        end
      end
      if (!abort_hit) out_kind_d[high_bit(mask_q)] = KIND_ABORT;
      rowbuf_data_d = '0;
      rowbuf_kind_d = '0;
      slot_d        = low_bit(mask_q);
      state_d       = S_IDLE;
    end else if (accept) begin
      mask_d = m_cur;
      if (!has_nxt || s_axi_last) begin
        out_data_d    = row_data;
        out_kind_d    = row_kind;
        rowbuf_data_d = '0;
        rowbuf_kind_d = '0;
        slot_d        = low_bit(m_cur);
      end else begin
        rowbuf_data_d = row_data;
        rowbuf_kind_d = row_kind;
        slot_d        = nxt_slot;
      end
      if (s_axi_last) begin
        state_d = S_IDLE;
        count_d = count_q + CNT_W'(1);
      end else begin
        state_d = S_FRAME;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= LANES'(1);
      slot_q        <= '0;
      rowbuf_data_q <= '0;
      rowbuf_kind_q <= '0;
      out_data_q    <= '0;
      out_kind_q    <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      slot_q        <= slot_d;
      rowbuf_data_q <= rowbuf_data_d;
      rowbuf_kind_q <= rowbuf_kind_d;
      out_data_q    <= out_data_d;
      out_kind_q    <= out_kind_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_aurora_lane_striper.sv
// Bench for aurora_lane_striper: directed vector table, then random traffic against
// a word-position model of the striping rules.
module tb_aurora_lane_striper;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    link_ready;
  logic [LANES-1:0]        lane_mask;
  logic                    s_axi_valid;
  logic                    s_axi_ready;
  logic                    s_axi_last;
  logic [DATA_W-1:0]       s_axi_data;
  logic [LANES*DATA_W-1:0] lane_data;
  logic [LANES*2-1:0]      lane_kind;
  logic [CNT_W-1:0]        frame_count;

  aurora_lane_striper #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .link_ready(link_ready), .lane_mask(lane_mask),
    .s_axi_valid(s_axi_valid), .s_axi_ready(s_axi_ready), .s_axi_last(s_axi_last),
    .s_axi_data(s_axi_data), .lane_data(lane_data), .lane_kind(lane_kind),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r, lk, v, la;
    logic [3:0]  mk;
    logic [15:0] d;
    logic [63:0] ed;
    logic [7:0]  ek;
    int          ec;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   miscompares = 0;

  // Reference model: a frame is a list of enabled lanes; the k-th word of a row goes to list[k].
  bit          m_in_frame = 1'b0;
  int          m_lanes[$];
  int          m_k = 0;
  int          m_cnt = 0;
  logic [15:0] m_rd[4];
  logic [1:0]  m_rk[4];
  logic [63:0] exp_d;
  logic [7:0]  exp_k;

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_rd[i] = '0;
      m_rk[i] = '0;
    end
    m_k = 0;
  endtask

  task automatic m_emit();
    for (int i = 0; i < 4; i++) begin
      exp_d[i*16 +: 16] = m_rd[i];
      exp_k[i*2 +: 2]   = m_rk[i];
    end
  endtask

  task automatic model_step(input bit r, lk, v, la, input logic [3:0] mk, input logic [15:0] d);
    exp_d = '0;
    exp_k = '0;
    if (r) begin
      m_in_frame = 1'b0;
      m_cnt = 0;
      m_clear();
    end else if (m_in_frame && !lk) begin
      m_rk[m_lanes[(m_k < m_lanes.size()) ? m_k : m_lanes.size() - 1]] = 2'b11;
      m_emit();
      m_in_frame = 1'b0;
      m_clear();
    end else if (v && lk) begin
      if (!m_in_frame) begin
        logic [3:0] mm;
        mm = (mk == 4'd0) ? 4'd1 : mk;
        m_lanes.delete();
        for (int i = 0; i < 4; i++) if (mm[i]) m_lanes.push_back(i);
        m_in_frame = 1'b1;
      end
      m_rd[m_lanes[m_k]] = d;
      m_rk[m_lanes[m_k]] = la ? 2'b10 : 2'b01;
      m_k++;
      if (m_k == m_lanes.size() || la) begin
        m_emit();
        m_clear();
      end
      if (la) begin
        m_in_frame = 1'b0;
        m_cnt++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input bit r, lk, v, la, input logic [3:0] mk, input logic [15:0] d,
                       input bit use_tbl, input logic [63:0] td, input logic [7:0] tk, input int tc,
                       input string tag);
    rst = r; link_ready = lk; s_axi_valid = v; s_axi_last = la; lane_mask = mk; s_axi_data = d;
    #1;
    chk({tag, " ready"}, 64'(s_axi_ready), 64'(lk && !r));
    model_step(r, lk, v, la, mk, d);
    @(posedge clk);
    #1;
    if (use_tbl) begin
      chk({tag, " data"}, lane_data, td);
      chk({tag, " kind"}, 64'(lane_kind), 64'(tk));
      chk({tag, " count"}, 64'(frame_count), 64'(tc % 4));
    end else begin
      chk({tag, " data"}, lane_data, exp_d);
      chk({tag, " kind"}, 64'(lane_kind), 64'(exp_k));
      chk({tag, " count"}, 64'(frame_count), 64'(m_cnt % 4));
    end
  endtask

  function automatic vec_t mkv(bit r, lk, v, la, logic [3:0] mk, logic [15:0] d,
                               logic [63:0] ed, logic [7:0] ek, int ec);
    vec_t t;
    t.r = r; t.lk = lk; t.v = v; t.la = la; t.mk = mk; t.d = d;
    t.ed = ed; t.ek = ek; t.ec = ec;
    return t;
  endfunction

  initial begin
    // reset
    tbl.push_back(mkv(1, 1, 0, 0, 4'hF, 16'h0, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 4'hF, 16'h1, 64'h0, 8'h00, 0));
    // four-lane frame D0..D5
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0A00, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0A01, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0A02, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0A03, {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00}, 8'h55, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0A04, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 4'hF, 16'h0A05, {16'h0, 16'h0, 16'h0A05, 16'h0A04}, 8'h09, 1));
    // sparse mask 1010
    tbl.push_back(mkv(0, 1, 1, 0, 4'hA, 16'h0B00, 64'h0, 8'h00, 1));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hA, 16'h0B01, {16'h0B01, 16'h0, 16'h0B00, 16'h0}, 8'h44, 1));
    tbl.push_back(mkv(0, 1, 1, 1, 4'hA, 16'h0B02, {16'h0, 16'h0, 16'h0B02, 16'h0}, 8'h08, 2));
    // zero mask -> lane 0 only
    tbl.push_back(mkv(0, 1, 1, 0, 4'h0, 16'h0C00, {48'h0, 16'h0C00}, 8'h01, 2));
    tbl.push_back(mkv(0, 1, 1, 0, 4'h0, 16'h0C01, {48'h0, 16'h0C01}, 8'h01, 2));
    tbl.push_back(mkv(0, 1, 1, 1, 4'h0, 16'h0C02, {48'h0, 16'h0C02}, 8'h02, 3));
    tbl.push_back(mkv(0, 1, 0, 0, 4'hF, 16'h0, 64'h0, 8'h00, 3));
    // mask change mid-frame, count wraps on 4th frame
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0D00, 64'h0, 8'h00, 3));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0D01, 64'h0, 8'h00, 3));
    tbl.push_back(mkv(0, 1, 1, 0, 4'h3, 16'h0D02, 64'h0, 8'h00, 3));
    tbl.push_back(mkv(0, 1, 1, 0, 4'h3, 16'h0D03, {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00}, 8'h55, 3));
    tbl.push_back(mkv(0, 1, 1, 0, 4'h3, 16'h0D04, 64'h0, 8'h00, 3));
    tbl.push_back(mkv(0, 1, 1, 1, 4'h3, 16'h0D05, {16'h0, 16'h0, 16'h0D05, 16'h0D04}, 8'h09, 0));
    // back-to-back frame on lanes 0-1; fifth frame -> count 1
    tbl.push_back(mkv(0, 1, 1, 0, 4'h3, 16'h0E00, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 4'h3, 16'h0E01, {16'h0, 16'h0, 16'h0E01, 16'h0E00}, 8'h05, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 4'h3, 16'h0E02, {48'h0, 16'h0E02}, 8'h02, 1));
    // abort after two words
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0F00, 64'h0, 8'h00, 1));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h0F01, 64'h0, 8'h00, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 4'hF, 16'h0F02, {16'h0, 16'h0, 16'h0F01, 16'h0F00}, 8'h35, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 4'hF, 16'h0F03, 64'h0, 8'h00, 1));
    // reset with two words buffered
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h1000, 64'h0, 8'h00, 1));
    tbl.push_back(mkv(0, 1, 1, 0, 4'hF, 16'h1001, 64'h0, 8'h00, 1));
    tbl.push_back(mkv(1, 1, 1, 0, 4'hF, 16'h1002, 64'h0, 8'h00, 0));
    tbl.push_back(mkv(0, 1, 0, 0, 4'hF, 16'h0, 64'h0, 8'h00, 0));

    foreach (tbl[i])
      apply(tbl[i].r, tbl[i].lk, tbl[i].v, tbl[i].la, tbl[i].mk, tbl[i].d,
            1'b1, tbl[i].ed, tbl[i].ek, tbl[i].ec, $sformatf("vec%0d", i));

    // abort with an empty row buffer on mask 0110: lowest enabled lane carries abort
    apply(0, 1, 1, 0, 4'h6, 16'h1100, 1'b1, 64'h0, 8'h00, 0, "eab0");
    apply(0, 1, 1, 0, 4'h6, 16'h1101, 1'b1, {16'h0, 16'h1101, 16'h1100, 16'h0}, 8'h14, 0, "eab1");
    apply(0, 0, 0, 0, 4'h6, 16'h0, 1'b1, 64'h0, 8'h0C, 0, "eab2");
    apply(0, 1, 0, 0, 4'h6, 16'h0, 1'b1, 64'h0, 8'h00, 0, "eab3");

    for (int n = 0; n < 600; n++) begin
      bit r, lk, v, la;
      r  = ($urandom_range(99) < 2);
      lk = ($urandom_range(99) >= 8);
      v  = ($urandom_range(99) < 75);
      la = ($urandom_range(99) < 22);
      apply(r, lk, v, la, 4'($urandom_range(15)), 16'($urandom), 1'b0, 64'h0, 8'h0, 0,
            $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
